uart_tx_arbiter: RTL and testbench

//  Shares one uart_tx instance between NumReq byte-stream requesters. Grants are

---
 rtl/uart_tx_arbiter.sv | 99 +++++++++
 tb/tb_uart_tx_arbiter.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one uart_tx among NumReq byte streams
module uart_tx_arbiter #(
  parameter int NumReq = 4,
  parameter int DataBits = 8,
  parameter int GapCycles = 0,
  parameter int TimeoutCycles = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NumReq*DataBits-1:0] req_data,
  input  logic [NumReq-1:0]          req_valid,
  input  logic [NumReq-1:0]          req_last,
  output logic [NumReq-1:0]          req_ready,
  output logic [DataBits-1:0]        tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic [NumReq-1:0]          grant,
  output logic                       busy,
  output logic                       abort
);
  localparam int PW = $clog2(NumReq);
  localparam int GW = GapCycles > 0 ? $clog2(GapCycles + 1) : 1;
  localparam int TW = TimeoutCycles > 0 ? $clog2(TimeoutCycles + 1) : 1;
  localparam int GL = GapCycles > 0 ? GapCycles - 1 : 0;
  localparam int TL = TimeoutCycles > 0 ? TimeoutCycles - 1 : 0;
  typedef enum logic [1:0] {ARB, SEND, GAP} state_t;
  state_t state, state_n;
  logic [PW-1:0] rr_ptr, rr_n, gidx, gidx_n, pick, nxt;
  logic [NumReq-1:0] grant_n;
  logic [GW-1:0] gcnt, gcnt_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic abort_n, found, vg, xfer, done, tout;
  always_comb begin
    pick = rr_ptr;
    found = 1'b0;
    for (int i = 0; i < NumReq; i++) begin
      if (!found && req_valid[PW'((int'(rr_ptr) + i) % NumReq)]) begin
        found = 1'b1;
        pick = PW'((int'(rr_ptr) + i) % NumReq);
      end
    end
  end
  assign nxt = (gidx == PW'(NumReq - 1)) ? '0 : gidx + 1'b1;
  assign vg = (state == SEND) && req_valid[gidx];
  assign xfer = vg && tx_ready;
  assign done = xfer && req_last[gidx];
  // the counter reaching TL means this is the TimeoutCycles-th idle cycle
  assign tout = (TimeoutCycles != 0) && (state == SEND) && !req_valid[gidx] && (tcnt == TW'(TL));
  assign tx_valid = vg;
  assign tx_data = (state == SEND) ? req_data[gidx*DataBits +: DataBits] : '0;
  assign req_ready = xfer ? grant : '0;
  assign busy = state != ARB;
  always_comb begin
    state_n = state;
    rr_n = rr_ptr;
    gidx_n = gidx;
    grant_n = grant;
    gcnt_n = gcnt;
    tcnt_n = tcnt;
    abort_n = 1'b0;
    if (state == ARB && found) begin
      state_n = SEND;
      gidx_n = pick;
      grant_n = NumReq'(1) << pick;
      tcnt_n = '0;
    end
    if (done || tout) begin
      state_n = GapCycles > 0 ? GAP : ARB;
      rr_n = nxt;
      grant_n = '0;
      gcnt_n = '0;
      abort_n = tout;
    end else if (xfer) tcnt_n = '0;
    else if (state == SEND && !req_valid[gidx] && tcnt != '1) tcnt_n = tcnt + 1'b1;
    if (state == GAP) begin
      state_n = (gcnt == GW'(GL)) ? ARB : GAP;
      gcnt_n = (gcnt == '1) ? gcnt : gcnt + 1'b1;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB;
      rr_ptr <= '0;
      gidx <= '0;
      grant <= '0;
      gcnt <= '0;
      tcnt <= '0;
      abort <= 1'b0;
    end else begin
      state <= state_n;
      rr_ptr <= rr_n;
      gidx <= gidx_n;
      grant <= grant_n;
      gcnt <= gcnt_n;
      tcnt <= tcnt_n;
      abort <= abort_n;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of arbitration, fairness, gap, timeout and reset
module tb_uart_tx_arbiter;
  logic clk = 1'b0, rst = 1'b1, tx_ready = 1'b1, g_tx_ready = 1'b1;
  logic [31:0] req_data = '0, g_req_data = '0;
  logic [3:0] req_valid = '0, req_last = '0, g_req_valid = '0, g_req_last = '0;
  logic [3:0] req_ready, grant, g_req_ready, g_grant;
  logic [7:0] tx_data, g_tx_data;
  logic tx_valid, busy, abort, g_tx_valid, g_busy, g_abort;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.NumReq(4), .DataBits(8), .GapCycles(0), .TimeoutCycles(16)) dut (
    .clk(clk), .rst(rst), .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .busy(busy), .abort(abort)
  );
  uart_tx_arbiter #(.NumReq(4), .DataBits(8), .GapCycles(5), .TimeoutCycles(1024)) dut_gap (
    .clk(clk), .rst(rst), .req_data(g_req_data), .req_valid(g_req_valid), .req_last(g_req_last),
    .req_ready(g_req_ready), .tx_data(g_tx_data), .tx_valid(g_tx_valid), .tx_ready(g_tx_ready),
    .grant(g_grant), .busy(g_busy), .abort(g_abort)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [1:0] i, input logic v, input logic [7:0] d, input logic l);
    req_valid[i] = v;
    req_data[i*8 +: 8] = d;
    req_last[i] = l;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tick;
    tick;
    chk("rst_grant", grant, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_rdy", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) put(2'(i), 1'b1, 8'(8'h50 + i), 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("fair_grant", grant, 32'd1 << (i % 4));
      chk("fair_data", tx_data, 32'h50 + i % 4);
      chk("fair_rdy", req_ready, 32'd1 << (i % 4));
      tick;
      chk("fair_arb", grant, 0);
    end
    for (int i = 0; i < 4; i++) put(2'(i), 1'b0, 8'h00, 1'b0);
    put(2'd1, 1'b1, 8'h41, 1'b0);
    tick;
    chk("single_grant", grant, 4'b0010);
    chk("single_d0", tx_data, 8'h41);
    chk("single_rdy0", req_ready, 4'b0010);
    chk("single_busy", busy, 1);
    tick;
    put(2'd1, 1'b1, 8'h42, 1'b1);
    tx_ready = 1'b0;
    #1;
    chk("stall_txv", tx_valid, 1);
    chk("stall_rdy", req_ready, 0);
    chk("stall_d1", tx_data, 8'h42);
    tick;
    tx_ready = 1'b1;
    #1;
    chk("single_grant1", grant, 4'b0010);
    chk("single_rdy1", req_ready, 4'b0010);
    tick;
    put(2'd1, 1'b0, 8'h00, 1'b0);
    #1;
    chk("single_done", {busy, grant}, 0);
    put(2'd0, 1'b1, 8'hA0, 1'b1);
    put(2'd2, 1'b1, 8'hC0, 1'b1);
    tick;
    chk("cont_first", grant, 4'b0100);
    chk("cont_d2", tx_data, 8'hC0);
    tick;
    put(2'd2, 1'b0, 8'h00, 1'b0);
    #1;
    chk("cont_arb", {tx_valid, grant}, 0);
    tick;
    chk("cont_second", grant, 4'b0001);
    chk("cont_d0", tx_data, 8'hA0);
    tick;
    put(2'd0, 1'b0, 8'h00, 1'b0);
    put(2'd3, 1'b1, 8'h10, 1'b0);
    tick;
    chk("to_grant", grant, 4'b1000);
    chk("to_data", tx_data, 8'h10);
    tick;
    put(2'd3, 1'b0, 8'h00, 1'b0);
    put(2'd1, 1'b1, 8'h11, 1'b1);
    for (int k = 1; k < 16; k++) begin
      tick;
      chk("to_wait", {abort, grant}, 5'b0_1000);
    end
    tick;
    chk("to_abort", {abort, busy, grant}, 6'b10_0000);
    tick;
    chk("to_pulse", abort, 0);
    chk("to_next", grant, 4'b0010);
    chk("to_next_d", tx_data, 8'h11);
    tick;
    put(2'd1, 1'b0, 8'h00, 1'b0);
    put(2'd2, 1'b1, 8'h20, 1'b0);
    tx_ready = 1'b0;
    tick;
    chk("mid_grant", {tx_valid, grant}, 5'b1_0100);
    tx_ready = 1'b1;
    rst = 1'b1;
    #1;
    chk("mid_rst", {tx_valid, busy, req_ready, grant}, 0);
    tick;
    chk("mid_hold", {tx_valid, req_ready, grant}, 0);
    put(2'd2, 1'b1, 8'h21, 1'b1);
    put(2'd0, 1'b1, 8'h01, 1'b0);
    rst = 1'b0;
    tick;
    chk("post_grant", grant, 4'b0001);
    chk("post_d0", tx_data, 8'h01);
    tick;
    put(2'd0, 1'b1, 8'h02, 1'b1);
    #1;
    chk("post_atomic", grant, 4'b0001);
    chk("post_d1", tx_data, 8'h02);
    chk("post_rdy", req_ready, 4'b0001);
    tick;
    put(2'd0, 1'b0, 8'h00, 1'b0);
    #1;
    chk("post_arb", {tx_valid, grant}, 0);
    tick;
    chk("post_next", grant, 4'b0100);
    chk("post_next_d", tx_data, 8'h21);
    tick;
    put(2'd2, 1'b0, 8'h00, 1'b0);
    g_req_data = 32'h0000_7877;
    g_req_last = 4'b0011;
    g_req_valid = 4'b0011;
    tick;
    chk("gap_grant", g_grant, 4'b0001);
    chk("gap_d0", g_tx_data, 8'h77);
    tick;
    g_req_valid = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("gap_idle", {g_tx_valid, g_busy, g_grant}, 6'b01_0000);
      tick;
    end
    chk("gap_arb", {g_tx_valid, g_busy, g_grant}, 0);
    tick;
    chk("gap_next", g_grant, 4'b0010);
    chk("gap_next_d", g_tx_data, 8'h78);
    tick;
    g_req_valid = 4'b0000;
    tick;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
